// File: rtl/unified_mem_arbiter_if.sv
// Signal bundle between the IF/MEM pipeline stages, the unified memory arbiter
// and the backing single-port memory.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Handshake: a requester raises x_req and holds it, with stable address and
  // data, until x_ready pulses for one cycle; x_rdata is valid from that cycle
  // on. A req still high during its own ready cycle is the finished request.
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              if_stall;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;
  logic              dm_stall;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ready, if_stall, dm_rdata, dm_ready, dm_stall,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ready, if_stall, dm_rdata, dm_ready, dm_stall,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one fixed-latency unified memory between instruction fetch and the
// MEM stage; DM wins ties, and a just-completed port yields for one cycle.
module unified_mem_arbiter #(
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  unified_mem_arbiter_if.slave     bus,
  output logic [1:0]               dbg_state
);
  localparam int CNT_W = $clog2(LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_we;
  logic [DATA_W-1:0] if_rdata_r, dm_rdata_r;
  logic              if_ready_r, dm_ready_r;

  logic if_elig, dm_elig;
  logic grant_if, grant_dm, done;

  // The request seen during its own ready cycle is the one just served.
  assign if_elig = bus.if_req & ~if_ready_r;
  assign dm_elig = bus.dm_req & ~dm_ready_r;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant_if   = 1'b0;
    grant_dm   = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (dm_elig) begin
          state_next = BUSY_DM;
          grant_dm   = 1'b1;
        end else if (if_elig) begin
          state_next = BUSY_IF;
          grant_if   = 1'b1;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (cnt == '0) begin
          state_next = IDLE;
          done       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_we     <= 1'b0;
      if_rdata_r <= '0;
      dm_rdata_r <= '0;
      if_ready_r <= 1'b0;
      dm_ready_r <= 1'b0;
    end else begin
      if_ready_r <= done && (state == BUSY_IF);
      dm_ready_r <= done && (state == BUSY_DM);
      if (grant_dm) begin
        lat_addr  <= bus.dm_addr;
        lat_wdata <= bus.dm_wdata;
        lat_we    <= bus.dm_we;
        cnt       <= CNT_INIT;
      end else if (grant_if) begin
        lat_addr  <= bus.if_addr;
        lat_we    <= 1'b0;
        cnt       <= CNT_INIT;
      end else if ((state != IDLE) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if (done && (state == BUSY_IF))
        if_rdata_r <= bus.mem_rdata;
      // A store leaves the previous load data in place.
      if (done && (state == BUSY_DM) && !lat_we)
        dm_rdata_r <= bus.mem_rdata;
    end
  end

  assign bus.mem_en    = (state != IDLE);
  assign bus.mem_we    = (state == BUSY_DM) && lat_we && (cnt == '0);
  assign bus.mem_addr  = lat_addr;
  assign bus.mem_wdata = lat_wdata;
  assign bus.busy      = (state != IDLE);

  assign bus.if_rdata  = if_rdata_r;
  assign bus.dm_rdata  = dm_rdata_r;
  assign bus.if_ready  = if_ready_r;
  assign bus.dm_ready  = dm_ready_r;
  assign bus.if_stall  = bus.if_req & ~if_ready_r;
  assign bus.dm_stall  = bus.dm_req & ~dm_ready_r;

  assign dbg_state = state;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with LATENCY=2 and a small word
// memory model attached to the mem_* side.
module tb_unified_mem_arbiter;
  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  logic       load_mem;
  int         n_checks;
  int         n_pass;
  int         write_cnt;

  logic [31:0] mem [0:255];

  unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  unified_mem_arbiter #(.LATENCY(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: combinational read, write on the strobed edge
  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hF000_0000 | i;
      mem[1] <= 32'h8C08_0000;
      mem[2] <= 32'h0022_1820;
      mem[3] <= 32'hA5A5_0003;
      mem[4] <= 32'h0000_0055;
      mem[8] <= 32'h1111_1111;
      write_cnt <= 0;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
      write_cnt <= write_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      n_pass++;
  endtask

  // driver tasks: inputs change just after the edge, outputs sampled at negedge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    load_mem = 1'b1;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.dm_req   = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;

    // reset with both requests pending
    tick();
    load_mem    = 1'b0;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0004;
    bus.dm_req  = 1'b1;
    bus.dm_addr = 32'h0000_0010;
    tick(); sample();
    check("rst_mem_en",   32'(bus.mem_en),   32'd0);
    check("rst_mem_we",   32'(bus.mem_we),   32'd0);
    check("rst_busy",     32'(bus.busy),     32'd0);
    check("rst_if_ready", 32'(bus.if_ready), 32'd0);
    check("rst_dm_ready", 32'(bus.dm_ready), 32'd0);
    check("rst_mem_addr", bus.mem_addr,      32'd0);
    check("rst_mem_wdata", bus.mem_wdata,    32'd0);
    check("rst_if_rdata", bus.if_rdata,      32'd0);
    check("rst_dm_rdata", bus.dm_rdata,      32'd0);
    check("rst_state",    32'(dbg_state),    32'd0);
    tick(); rst = 1'b0; sample();
    check("rel_no_grant", 32'(bus.mem_en),   32'd0);
    check("rel_dm_stall", 32'(bus.dm_stall), 32'd1);
    check("rel_if_stall", 32'(bus.if_stall), 32'd1);
    // both requests dropped after the DM grant: DM completes, IF is lost
    tick(); bus.if_req = 1'b0; bus.dm_req = 1'b0; sample();
    check("rel_grant_en",   32'(bus.mem_en),  32'd1);
    check("rel_grant_addr", bus.mem_addr,     32'h0000_0010);
    check("rel_grant_dm",   32'(dbg_state),   32'd2);
    tick(); tick(); sample();
    check("drop_dm_ready", 32'(bus.dm_ready), 32'd1);
    check("drop_dm_rdata", bus.dm_rdata,      32'h0000_0055);
    tick(); sample();
    check("drop_if_lost",  32'(bus.busy),     32'd0);
    check("drop_if_ready", 32'(bus.if_ready), 32'd0);
    quiet(2);

    // lone fetch
    tick(); bus.if_req = 1'b1; bus.if_addr = 32'h0000_0004; sample();
    check("lf_t0_stall", 32'(bus.if_stall), 32'd1);
    check("lf_t0_en",    32'(bus.mem_en),   32'd0);
    tick(); sample();
    check("lf_t1_en",    32'(bus.mem_en),   32'd1);
    check("lf_t1_addr",  bus.mem_addr,      32'h0000_0004);
    check("lf_t1_stall", 32'(bus.if_stall), 32'd1);
    tick(); sample();
    check("lf_t2_en",    32'(bus.mem_en),   32'd1);
    check("lf_t2_stall", 32'(bus.if_stall), 32'd1);
    tick(); sample();
    check("lf_t3_ready", 32'(bus.if_ready), 32'd1);
    check("lf_t3_rdata", bus.if_rdata,      32'h8C08_0000);
    check("lf_t3_stall", 32'(bus.if_stall), 32'd0);
    check("lf_t3_en",    32'(bus.mem_en),   32'd0);
    tick(); bus.if_req = 1'b0; sample();
    check("lf_t4_ready", 32'(bus.if_ready), 32'd0);
    quiet(2);

    // simultaneous fetch and load
    tick();
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0008;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h0000_0010;
    sample();
    tick(); sample();
    check("sim_t1_addr", bus.mem_addr, 32'h0000_0010);
    tick(); tick(); sample();
    check("sim_t3_dm_ready", 32'(bus.dm_ready), 32'd1);
    check("sim_t3_dm_rdata", bus.dm_rdata,      32'h0000_0055);
    check("sim_t3_if_ready", 32'(bus.if_ready), 32'd0);
    check("sim_t3_if_stall", 32'(bus.if_stall), 32'd1);
    tick(); bus.dm_req = 1'b0; sample();
    check("sim_t4_addr", bus.mem_addr,     32'h0000_0008);
    check("sim_t4_en",   32'(bus.mem_en),  32'd1);
    tick(); tick(); sample();
    check("sim_t6_if_ready", 32'(bus.if_ready), 32'd1);
    check("sim_t6_if_rdata", bus.if_rdata,      32'h0022_1820);
    tick(); bus.if_req = 1'b0;
    quiet(2);

    // store then load back
    tick();
    bus.dm_req = 1'b1; bus.dm_we = 1'b1;
    bus.dm_addr = 32'h0000_0020; bus.dm_wdata = 32'hDEAD_BEEF;
    sample();
    tick(); sample();
    check("st_t1_we",    32'(bus.mem_we), 32'd0);
    check("st_t1_wdata", bus.mem_wdata,   32'hDEAD_BEEF);
    tick(); sample();
    check("st_t2_we",    32'(bus.mem_we), 32'd1);
    tick(); sample();
    check("st_t3_ready", 32'(bus.dm_ready), 32'd1);
    check("st_t3_rdata", bus.dm_rdata,      32'h0000_0055);
    check("st_t3_we",    32'(bus.mem_we),   32'd0);
    tick(); bus.dm_req = 1'b0;
    tick(); bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h0000_0020;
    tick(); tick(); tick(); sample();
    check("ld_ready", 32'(bus.dm_ready), 32'd1);
    check("ld_rdata", bus.dm_rdata,      32'hDEAD_BEEF);
    tick(); bus.dm_req = 1'b0;
    quiet(2);

    // reset in the middle of a store
    tick();
    bus.dm_req = 1'b1; bus.dm_we = 1'b1;
    bus.dm_addr = 32'h0000_0020; bus.dm_wdata = 32'h1234_5678;
    tick(); rst = 1'b1; sample();
    check("rs_t1_en", 32'(bus.mem_en), 32'd1);
    check("rs_t1_we", 32'(bus.mem_we), 32'd0);
    tick(); rst = 1'b0; bus.dm_req = 1'b0; bus.dm_we = 1'b0; sample();
    check("rs_t2_state",  32'(dbg_state),    32'd0);
    check("rs_t2_en",     32'(bus.mem_en),   32'd0);
    check("rs_t2_we",     32'(bus.mem_we),   32'd0);
    check("rs_t2_ready",  32'(bus.dm_ready), 32'd0);
    check("rs_t2_rdata",  bus.dm_rdata,      32'd0);
    tick(); sample();
    check("rs_t3_ready",  32'(bus.dm_ready), 32'd0);
    check("rs_mem_kept",  mem[8],            32'hDEAD_BEEF);
    check("rs_write_cnt", 32'(write_cnt),    32'd1);
    quiet(2);

    // contention: DM always requesting, IF always requesting
    tick();
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0004;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h0000_0010;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) tick();
      if (k == 4) bus.dm_addr = 32'h0000_000C;
      if (k == 7) bus.if_addr = 32'h0000_0008;
      sample();
      check($sformatf("ct_dm_ready_%0d", k), 32'(bus.dm_ready), 32'((k == 3) || (k == 9)));
      check($sformatf("ct_if_ready_%0d", k), 32'(bus.if_ready), 32'((k == 6) || (k == 12)));
      if (k == 3)  check("ct_dm_rdata_3",  bus.dm_rdata, 32'h0000_0055);
      if (k == 6)  check("ct_if_rdata_6",  bus.if_rdata, 32'h8C08_0000);
      if (k == 9)  check("ct_dm_rdata_9",  bus.dm_rdata, 32'hA5A5_0003);
      if (k == 12) check("ct_if_rdata_12", bus.if_rdata, 32'h0022_1820);
    end
    tick(); bus.if_req = 1'b0; bus.dm_req = 1'b0;
    quiet(5);
    sample();
    check("end_idle", 32'(bus.busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Single-port memory arbiter that lets the instruction-fetch stage and the MEM stage share one unified instruction/data memory. Grants one access at a time, sequences the fixed-latency memory transaction, returns read data to the owning port and drives per-port stall signals into the pipeline. These stalls freeze the PC register and the pipeline registers. Sits between the IF/MEM stages of the 5-stage core and the backing memory.

## Interface
- LATENCY, 2, memory busy cycles per access (≥1)
- ADDR_W, 32, address width
- DATA_W, 32, data width

- clk  in  1  rising-edge clock, sole clock domain
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  ADDR_W  fetch address (currentPC)
- if_rdata  out  DATA_W  fetched instruction, registered
- if_ready  out  1  one-cycle completion pulse for fetch
- if_stall  out  1  if_req & ~if_ready
- dm_req  in  1  data request (MemRead | MemWrite), held until dm_ready
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_W  data address (ALU result)
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data, registered
- dm_ready  out  1  one-cycle completion pulse for data
- dm_stall  out  1  dm_req & ~dm_ready
- mem_en  out  1  memory access active
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid in last busy cycle
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, BUSY_IF, BUSY_DM. Down-counter cnt, width clog2(LATENCY)+1.
- IDLE:
  - If a DM request is eligible, go to BUSY_DM. Else if an IF request is eligible, go to BUSY_IF. DM has priority because it is the older instruction.
  - On the grant edge, latch the address, plus wdata and we for DM, into internal registers. Set cnt = LATENCY-1.
- Eligibility: a port's req is ignored in the cycle its own ready is high. That req is the stale, just-completed request. The other port's req may be granted in that cycle. This guarantees IF/DM alternation under contention, so neither port starves.
- BUSY_x:
  - mem_en = 1; mem_addr and mem_wdata come from the latched registers and stay stable for the whole access.
  - Decrement cnt each cycle.
  - mem_we = 1 only in BUSY_DM with a latched we while cnt == 0. The write commits on that single cycle only.
- Completion edge (cnt == 0):
  - On a read, register mem_rdata into x_rdata.
  - On a DM write, dm_rdata holds its previous value.
  - Set x_ready = 1 for exactly the next cycle and go to IDLE.
- x_rdata holds its value until the next completed read on the same port.
- mem_en, mem_we = 0 in IDLE. mem_addr and mem_wdata hold their last latched values.
- stall outputs are combinational from the req inputs and the registered ready signals. No other combinational paths run from inputs to outputs.
- Reset: state IDLE, cnt 0, all outputs 0 (rdata, ready, mem_*, busy), latched registers 0.
- Reset mid-access:
  - Abort with no ready pulse. mem_en falls on the following cycle.
  - A write reset before its cnt == 0 cycle never asserts mem_we, so memory is untouched.
- Requests are not queued. A requester that drops req before ready while it is not yet granted simply loses the request. Dropping req after grant has no effect: the access completes and ready still pulses.

## Timing
- Request sampled in IDLE at edge T:
  - mem_en is high cycles T+1 … T+LATENCY.
  - ready pulses in cycle T+LATENCY+1.
  - Request-to-ready latency is LATENCY+1 cycles.
- Back-to-back accesses on alternating ports: next grant at the end of the ready cycle, giving throughput of one access per LATENCY+1 cycles.
- Simultaneous IF and DM requests at T:
  - dm_ready pulses at T+LATENCY+1.
  - IF is granted on that cycle's edge, and if_ready pulses at T+2·(LATENCY+1).
- if_stall and dm_stall are high in every cycle that their req is high except the ready cycle.

## Test plan
- Reset: assert rst for 2 cycles with both req high → all outputs 0, busy 0; no grant until the cycle after rst drops.
- Lone fetch (LATENCY=2): if_addr=0x0000_0004 at T, mem returns 0x8C08_0000 → mem_en high T+1,T+2; if_ready at T+3 with if_rdata=0x8C08_0000; if_stall high T..T+2.
- Simultaneous: if_req and dm_req (read 0x0000_0010 → 0x0000_0055) at T → dm_ready at T+3 with dm_rdata=0x55; if_ready at T+6; mem_addr switches to if_addr at T+4.
- Store: dm_we=1, dm_addr=0x20, dm_wdata=0xDEAD_BEEF at T → mem_we high only at T+2; dm_ready at T+3; dm_rdata unchanged; a following load of 0x20 returns 0xDEAD_BEEF.
- Reset during store: rst at T+1 → mem_we never high, no dm_ready, location 0x20 keeps its old value, state IDLE at T+2.
- Contention: dm_req held high continuously with new addresses each ready, if_req pending → grants alternate DM, IF, DM, IF; no port waits more than 2·(LATENCY+1) cycles.
